// File: rtl/or_gate_pkg.sv
// -----------------------------------------------------------------------------
// or_gate_pkg
// Shared constants and helpers for the or_gate primitive.
//   OR_GATE_WIDTH_DEF : default operand width
//   OR_GATE_CNT_W_DEF : default hit-counter width
//   sat_inc()         : increment that sticks at a supplied maximum
// -----------------------------------------------------------------------------
package or_gate_pkg;

   localparam int OR_GATE_WIDTH_DEF = 1;
   localparam int OR_GATE_CNT_W_DEF = 8;

   // Counter widths up to 31 bits are carried in a 32-bit container.
   function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                           input logic [31:0] max_val);
      return (val >= max_val) ? val : val + 32'd1;
   endfunction

endpackage

// File: rtl/or_gate_sat_cnt.sv
// -----------------------------------------------------------------------------
// or_gate_sat_cnt
// Saturating up-counter with synchronous clear. Clear wins over increment.
// Ports:
//   clk_i    : clock, rising edge
//   rst_n_i  : asynchronous active-low reset
//   clear_i  : synchronous clear to zero
//   inc_i    : increment by one (holds at all-ones)
//   cnt_o    : current count
// -----------------------------------------------------------------------------
module or_gate_sat_cnt
   import or_gate_pkg::*;
#(
   parameter int CNT_W = OR_GATE_CNT_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             clear_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = CNT_W'(sat_inc(32'(cnt_q), CNT_MAX));
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/or_gate.sv
// -----------------------------------------------------------------------------
// or_gate
// Bitwise two-input OR with a combinational output, a valid-qualified
// registered output, and a saturating count of nonzero accepted samples.
// Optional feature macro: OR_GATE_STICKY_EN adds the Y_STICKY accumulator.
// Ports:
//   CLK       : clock, rising edge
//   RST_N     : asynchronous active-low reset
//   A, B      : operands
//   IN_VALID  : qualifies A/B for the registered stage
//   CLEAR     : synchronous clear of HIT_CNT (and Y_STICKY)
//   Y         : A | B, combinational
//   Y_REG     : A | B captured on valid cycles
//   OUT_VALID : IN_VALID delayed one cycle
//   Y_ANY     : reduction OR of Y_REG
//   HIT_CNT   : saturating count of accepted nonzero samples
//   Y_STICKY  : OR-accumulation of accepted samples (OR_GATE_STICKY_EN only)
// -----------------------------------------------------------------------------
module or_gate
   import or_gate_pkg::*;
#(
   parameter int WIDTH = OR_GATE_WIDTH_DEF,
   parameter int CNT_W = OR_GATE_CNT_W_DEF
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             IN_VALID,
   input  logic             CLEAR,
   output logic [WIDTH-1:0] Y,
   output logic [WIDTH-1:0] Y_REG,
   output logic             OUT_VALID,
   output logic             Y_ANY,
   output logic [CNT_W-1:0] HIT_CNT
`ifdef OR_GATE_STICKY_EN
   ,
   output logic [WIDTH-1:0] Y_STICKY
`endif
);

   logic [WIDTH-1:0] y_reg_q;
   logic [WIDTH-1:0] y_reg_d;
   logic             out_valid_q;
   logic             hit;

   assign Y = A | B;

   // Operands are only looked at behind IN_VALID so X on idle cycles
   // cannot leak into state.
   always_comb begin
      y_reg_d = y_reg_q;
      if (IN_VALID) begin
         y_reg_d = A | B;
      end
   end

   assign hit = IN_VALID && (|(A | B));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         y_reg_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         y_reg_q     <= y_reg_d;
         out_valid_q <= IN_VALID;
      end
   end

   assign Y_REG     = y_reg_q;
   assign OUT_VALID = out_valid_q;
   assign Y_ANY     = |y_reg_q;

   or_gate_sat_cnt #(
      .CNT_W(CNT_W)
   ) u_hit_cnt (
      .clk_i   (CLK),
      .rst_n_i (RST_N),
      .clear_i (CLEAR),
      .inc_i   (hit),
      .cnt_o   (HIT_CNT)
   );

`ifdef OR_GATE_STICKY_EN
   logic [WIDTH-1:0] sticky_q;
   logic [WIDTH-1:0] sticky_d;

   always_comb begin
      sticky_d = sticky_q;
      if (CLEAR) begin
         sticky_d = '0;
      end else if (IN_VALID) begin
         sticky_d = sticky_q | A | B;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sticky_q <= '0;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign Y_STICKY = sticky_q;
`endif

endmodule

// File: tb/tb_or_gate.sv
module tb_or_gate;

   logic CLK   = 1'b0;
   logic RST_N = 1'b0;

   logic [0:0] a1 = '0, b1 = '0;
   logic       v1 = 1'b0, c1 = 1'b0;
   logic [0:0] y1, yreg1;
   logic       ov1, yany1;
   logic [7:0] cnt1;

   logic [3:0] a4 = '0, b4 = '0;
   logic       v4 = 1'b0, c4 = 1'b0;
   logic [3:0] y4, yreg4;
   logic       ov4, yany4;
   logic [1:0] cnt4;

`ifdef OR_GATE_STICKY_EN
   logic [0:0] stk1;
   logic [3:0] stk4;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [0:0] yreg1;
      logic       ov1;
      logic [7:0] cnt1;
      logic [0:0] stk1;
      logic [3:0] yreg4;
      logic       ov4;
      logic [1:0] cnt4;
      logic [3:0] stk4;
   } exp_t;

   exp_t q[$];

   // reference state
   logic [0:0] m_yreg1 = '0, m_stk1 = '0;
   logic       m_ov1   = 1'b0;
   logic [7:0] m_cnt1  = '0;
   logic [3:0] m_yreg4 = '0, m_stk4 = '0;
   logic       m_ov4   = 1'b0;
   logic [1:0] m_cnt4  = '0;

   always #10 CLK = ~CLK;

   or_gate #(.WIDTH(1), .CNT_W(8)) u1 (
      .CLK(CLK), .RST_N(RST_N), .A(a1), .B(b1), .IN_VALID(v1), .CLEAR(c1),
      .Y(y1), .Y_REG(yreg1), .OUT_VALID(ov1), .Y_ANY(yany1), .HIT_CNT(cnt1)
`ifdef OR_GATE_STICKY_EN
      , .Y_STICKY(stk1)
`endif
   );

   or_gate #(.WIDTH(4), .CNT_W(2)) u4 (
      .CLK(CLK), .RST_N(RST_N), .A(a4), .B(b4), .IN_VALID(v4), .CLEAR(c4),
      .Y(y4), .Y_REG(yreg4), .OUT_VALID(ov4), .Y_ANY(yany4), .HIT_CNT(cnt4)
`ifdef OR_GATE_STICKY_EN
      , .Y_STICKY(stk4)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_yreg1"}, 32'(yreg1), 32'd0);
      chk({tag, "_ov1"},   32'(ov1),   32'd0);
      chk({tag, "_yany1"}, 32'(yany1), 32'd0);
      chk({tag, "_cnt1"},  32'(cnt1),  32'd0);
      chk({tag, "_yreg4"}, 32'(yreg4), 32'd0);
      chk({tag, "_ov4"},   32'(ov4),   32'd0);
      chk({tag, "_yany4"}, 32'(yany4), 32'd0);
      chk({tag, "_cnt4"},  32'(cnt4),  32'd0);
`ifdef OR_GATE_STICKY_EN
      chk({tag, "_stk1"},  32'(stk1),  32'd0);
      chk({tag, "_stk4"},  32'(stk4),  32'd0);
`endif
   endtask

   // Called just after a falling edge: drive, predict, cross one rising edge,
   // then compare at the next falling edge.
   task automatic step(input logic [0:0] a_1, input logic [0:0] b_1,
                       input logic v_1, input logic c_1,
                       input logic [3:0] a_4, input logic [3:0] b_4,
                       input logic v_4, input logic c_4);
      exp_t e;
      a1 = a_1; b1 = b_1; v1 = v_1; c1 = c_1;
      a4 = a_4; b4 = b_4; v4 = v_4; c4 = c_4;
      #1;
      if (v_1) chk("y1_comb", 32'(y1), 32'(a_1 | b_1));
      if (v_4) chk("y4_comb", 32'(y4), 32'(a_4 | b_4));

      if (c_1) m_cnt1 = '0;
      else if (v_1 && ((a_1 | b_1) != 0) && m_cnt1 != 8'hFF) m_cnt1 = m_cnt1 + 8'd1;
      if (c_1) m_stk1 = '0;
      else if (v_1) m_stk1 = m_stk1 | a_1 | b_1;
      if (v_1) m_yreg1 = a_1 | b_1;
      m_ov1 = v_1;

      if (c_4) m_cnt4 = '0;
      else if (v_4 && ((a_4 | b_4) != 0) && m_cnt4 != 2'd3) m_cnt4 = m_cnt4 + 2'd1;
      if (c_4) m_stk4 = '0;
      else if (v_4) m_stk4 = m_stk4 | a_4 | b_4;
      if (v_4) m_yreg4 = a_4 | b_4;
      m_ov4 = v_4;

      e.yreg1 = m_yreg1; e.ov1 = m_ov1; e.cnt1 = m_cnt1; e.stk1 = m_stk1;
      e.yreg4 = m_yreg4; e.ov4 = m_ov4; e.cnt4 = m_cnt4; e.stk4 = m_stk4;
      q.push_back(e);

      @(posedge CLK);
      @(negedge CLK);
      e = q.pop_front();
      chk("yreg1", 32'(yreg1), 32'(e.yreg1));
      chk("ov1",   32'(ov1),   32'(e.ov1));
      chk("yany1", 32'(yany1), 32'(|e.yreg1));
      chk("cnt1",  32'(cnt1),  32'(e.cnt1));
      chk("yreg4", 32'(yreg4), 32'(e.yreg4));
      chk("ov4",   32'(ov4),   32'(e.ov4));
      chk("yany4", 32'(yany4), 32'(|e.yreg4));
      chk("cnt4",  32'(cnt4),  32'(e.cnt4));
`ifdef OR_GATE_STICKY_EN
      chk("stk1",  32'(stk1),  32'(e.stk1));
      chk("stk4",  32'(stk4),  32'(e.stk4));
`endif
   endtask

   initial begin : watchdog
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [1:0] pat [4];
      pat[0] = 2'b00; pat[1] = 2'b10; pat[2] = 2'b01; pat[3] = 2'b11;

      // reset state, Y tracks A|B even in reset
      #5;
      chk_all_zero("rst");
      for (int i = 0; i < 4; i++) begin
         a1 = pat[i][1]; b1 = pat[i][0];
         #2;
         chk("y1_in_reset", 32'(y1), (i == 0) ? 32'd0 : 32'd1);
      end

      @(negedge CLK);
      RST_N = 1'b1;

      // combinational path, idle valid; u4 fed X while idle
      a4 = 'x; b4 = 'x; v4 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a1 = pat[i][1]; b1 = pat[i][0];
         for (int k = 0; k < 4; k++) begin
            #24;
            chk("y1_dwell", 32'(y1), (i == 0) ? 32'd0 : 32'd1);
         end
         #4;
      end
      @(negedge CLK);
      chk_all_zero("idle");

      // WIDTH=1 truth table through the registered stage
      step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      chk("cnt1_three", 32'(cnt1), 32'd3);

      // WIDTH=4 single valid pulse, then hold with X operands
      step(1'bx, 1'bx, 1'b0, 1'b0, 4'b0101, 4'b0010, 1'b1, 1'b0);
      chk("yreg4_0111", 32'(yreg4), 32'h7);
      step(1'b0, 1'b0, 1'b0, 1'b0, 4'hx, 4'hx, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);

      // clear, then saturation and sticky accumulation
      step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 4'h0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h4, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 4'h8, 4'h0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 4'h3, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 4'h1, 1'b1, 1'b0);
      chk("cnt4_sat", 32'(cnt4), 32'd3);

      // clear beats a simultaneous valid nonzero sample
      step(1'b1, 1'b0, 1'b1, 1'b1, 4'h4, 4'h0, 1'b1, 1'b1);
      chk("cnt4_clr_pri", 32'(cnt4), 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 4'h0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0);

      // Y_REG=F, HIT_CNT=2, then async reset between edges
      step(1'b1, 1'b1, 1'b1, 1'b0, 4'h1, 4'h0, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b0, 4'h1, 4'h0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 4'h0, 1'b1, 1'b0);
      chk("pre_rst_cnt4", 32'(cnt4), 32'd2);
      chk("pre_rst_yreg4", 32'(yreg4), 32'hF);

      #3;
      a4 = 4'h6; b4 = 4'h1;
      RST_N = 1'b0;
      #1;
      chk_all_zero("mid_rst");
      chk("y4_in_reset", 32'(y4), 32'h7);

      m_yreg1 = '0; m_stk1 = '0; m_ov1 = 1'b0; m_cnt1 = '0;
      m_yreg4 = '0; m_stk4 = '0; m_ov4 = 1'b0; m_cnt4 = '0;
      @(negedge CLK);
      RST_N = 1'b1;
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'h9, 4'h0, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
